// File: rtl/baud_gen_frac_pkg.sv
// baud_pkg: shared constants and helpers for the fractional baud generator.
// Provides clog2, reset-default divisor computation and MIN_DIV.
package baud_pkg;

  localparam int MIN_DIV = 2;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Integer clocks per sample tick for the default baud rate
  function automatic int def_int(
    input int sys_clk,
    input int baud,
    input int sr
  );
    longint d = longint'(baud) * sr;
    return int'(longint'(sys_clk) / d);
  endfunction

  // Rounded fractional remainder in units of 2^-fw
  function automatic int def_frac(
    input int sys_clk,
    input int baud,
    input int sr,
    input int fw
  );
    longint d = longint'(baud) * sr;
    longint r = longint'(sys_clk) % d;
    return int'(((r <<< fw) + d / 2) / d);
  endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// baud_gen_frac_if: control inputs and tick outputs of the baud generator.
// master drives en/sync_clr/div_*; slave (the generator) drives ticks/phase.
interface baud_gen_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 8,
  parameter int PH_W   = 4
);
  logic              en;
  logic              sync_clr;
  logic              div_load;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              sample_tick;
  logic              bit_tick;
  logic              mid_tick;
  logic [PH_W-1:0]   phase;

  modport master (
    output en, sync_clr, div_load, div_int, div_frac,
    input  sample_tick, bit_tick, mid_tick, phase
  );

  modport slave (
    input  en, sync_clr, div_load, div_int, div_frac,
    output sample_tick, bit_tick, mid_tick, phase
  );
endinterface

// File: rtl/baud_frac_div.sv
// baud_frac_div: period counter, dither accumulator, shadow/active divisor.
// Ports: clk, rst, en, sync_clr, div_load, div_int, div_frac -> bnd, sample_tick.
// BAUD_GEN_FRAC_EN: adds the fractional accumulator (else pure integer divider).
module baud_frac_div
  import baud_pkg::*;
#(
  parameter int SYS_CLK     = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int SAMPLE_RATE = 16,
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              bnd,
  output logic              sample_tick
);

  localparam int DEF_I = def_int(SYS_CLK, BAUD_RATE, SAMPLE_RATE);
  localparam logic [DIV_W-1:0] DEF_IV =
    DIV_W'(DEF_I < MIN_DIV ? MIN_DIV : DEF_I);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] act_int;
  logic [DIV_W-1:0] sh_int;
  logic [DIV_W-1:0] ld_int;
  logic [DIV_W:0]   per_m1;
  logic             pend;
  logic             carry;
  logic             promote;

  assign ld_int = (div_int < DIV_W'(MIN_DIV)) ?
                  DIV_W'(MIN_DIV) : div_int;

  // Load at a boundary, or at once while frozen
  assign promote = (pend | div_load) & (~en | bnd);

  assign per_m1 = {1'b0, act_int} + (DIV_W+1)'(carry)
                - (DIV_W+1)'(1);

  // >= keeps a shortened divisor from running cnt past the end
  assign bnd = en & ~sync_clr & ({1'b0, cnt} >= per_m1);

`ifdef BAUD_GEN_FRAC_EN
  localparam int DEF_F =
    def_frac(SYS_CLK, BAUD_RATE, SAMPLE_RATE, FRAC_W);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] acc_nx;
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] sh_frac;

  assign {carry, acc_nx} = {1'b0, acc} + {1'b0, act_frac};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      act_frac <= FRAC_W'(DEF_F);
      sh_frac  <= FRAC_W'(DEF_F);
    end else begin
      if (div_load) sh_frac <= div_frac;
      if (promote) act_frac <= div_load ? div_frac : sh_frac;
      if (sync_clr) acc <= '0;
      else if (bnd) acc <= acc_nx;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign carry = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      act_int     <= DEF_IV;
      sh_int      <= DEF_IV;
      pend        <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      if (div_load) sh_int <= ld_int;
      if (promote) begin
        act_int <= div_load ? ld_int : sh_int;
        pend    <= 1'b0;
      end else if (div_load) begin
        pend <= 1'b1;
      end
      sample_tick <= bnd;
      if (sync_clr | bnd) cnt <= '0;
      else if (en) cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional baud/oversample tick generator for UART TX/RX.
// Ports: clk, rst, bus (slave): sample_tick, bit_tick, mid_tick, phase out.
// BAUD_GEN_FRAC_EN enables fractional dithering in baud_frac_div.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int SYS_CLK     = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int SAMPLE_RATE = 16,
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 8
) (
  input logic            clk,
  input logic            rst,
  baud_gen_frac_if.slave bus
);

  localparam int PH_W = clog2(SAMPLE_RATE);

  logic            bnd;
  logic            bit_q;
  logic            mid_q;
  logic [PH_W-1:0] phase;

  baud_frac_div #(
    .SYS_CLK     (SYS_CLK),
    .BAUD_RATE   (BAUD_RATE),
    .SAMPLE_RATE (SAMPLE_RATE),
    .DIV_W       (DIV_W),
    .FRAC_W      (FRAC_W)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .en          (bus.en),
    .sync_clr    (bus.sync_clr),
    .div_load    (bus.div_load),
    .div_int     (bus.div_int),
    .div_frac    (bus.div_frac),
    .bnd         (bnd),
    .sample_tick (bus.sample_tick)
  );

  // Decoded on the boundary so they line up with sample_tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      bit_q <= 1'b0;
      mid_q <= 1'b0;
    end else begin
      bit_q <= bnd & (phase == PH_W'(SAMPLE_RATE - 1));
      mid_q <= bnd & (phase == PH_W'(SAMPLE_RATE / 2 - 1));
      if (bus.sync_clr) phase <= '0;
      else if (bnd) phase <= phase + PH_W'(1);
    end
  end

  assign bus.phase    = phase;
  assign bus.bit_tick = bit_q;
  assign bus.mid_tick = mid_q;

endmodule
